// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles every bus-level signal of the data-memory arbiter: the CPU data
// port, the secondary valid/ready requester, the secondary read return and
// the single-port BRAM port.
//   slave  modport : the arbiter's view (requests in, memory drive out)
//   master modport : the environment's view (requesters and BRAM model)
// Parameter ADDR_W : memory word-address width (must be <= 30).
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
   parameter int ADDR_W = 10
);
   // CPU data port
   logic              cpu_req;
   logic [3:0]        cpu_we;
   logic [31:0]       cpu_addr;
   logic [31:0]       cpu_wdata;
   logic [31:0]       cpu_rdata;
   logic              cpu_stall;
   // secondary requester
   logic              sec_valid;
   logic [3:0]        sec_we;
   logic [31:0]       sec_addr;
   logic [31:0]       sec_wdata;
   logic              sec_ready;
   logic              sec_rvalid;
   logic [31:0]       sec_rdata;
   // single-port BRAM, 1-cycle read latency
   logic              mem_en;
   logic [3:0]        mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  sec_valid, sec_we, sec_addr, sec_wdata,
      output sec_ready, sec_rvalid, sec_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output sec_valid, sec_we, sec_addr, sec_wdata,
      input  sec_ready, sec_rvalid, sec_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port BRAM between a CPU data port (priority owner) and a
// secondary valid/ready requester. The CPU wins whenever it requests, except
// that after STARVE_LIMIT consecutive denied secondary cycles the arbiter
// spends exactly one FORCED cycle in which the secondary owns the memory and
// the CPU is stalled.
// Ports:
//   sys_clk   : sole clock, rising edge
//   sys_rst_n : asynchronous active-low reset
//   bus       : dmem_arbiter_if.slave (CPU, secondary and BRAM signals)
// Parameters:
//   ADDR_W       : memory word-address width (<= 30)
//   STARVE_LIMIT : denied secondary cycles before a forced grant (1..15)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int ADDR_W       = 10,
   parameter int STARVE_LIMIT = 8
) (
   input  logic           sys_clk,
   input  logic           sys_rst_n,
   dmem_arbiter_if.slave  bus
);

   typedef enum logic [0:0] {
      ST_NORMAL = 1'b0,
      ST_FORCED = 1'b1
   } state_t;

   // counter value at which the next denial triggers the forced grant
   localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

   state_t            r_state;
   logic [3:0]        r_starve_cnt;
   logic              r_rd_pend;

   logic              w_mem_en;
   logic [3:0]        w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [31:0]       w_mem_wdata;
   logic              w_sec_ready;
   logic              w_cpu_stall;
   logic              w_handshake;
   logic [ADDR_W-1:0] w_cpu_word;
   logic [ADDR_W-1:0] w_sec_word;
   logic              w_unused_addr_bits;

   // byte address -> word address; low two bits and high bits are dropped
   assign w_cpu_word = bus.cpu_addr[ADDR_W+1:2];
   assign w_sec_word = bus.sec_addr[ADDR_W+1:2];
   assign w_unused_addr_bits = ^{bus.cpu_addr[31:ADDR_W+2], bus.cpu_addr[1:0],
                                 bus.sec_addr[31:ADDR_W+2], bus.sec_addr[1:0]};

   // Ownership decode: steers the BRAM port to the current owner
   always_comb begin
      w_mem_en    = 1'b0;
      w_mem_we    = 4'h0;
      w_mem_addr  = w_sec_word;
      w_mem_wdata = bus.sec_wdata;
      w_sec_ready = 1'b0;
      w_cpu_stall = 1'b0;
      case (r_state)
         ST_NORMAL: begin
            if (bus.cpu_req) begin
               w_mem_en    = 1'b1;
               w_mem_we    = bus.cpu_we;
               w_mem_addr  = w_cpu_word;
               w_mem_wdata = bus.cpu_wdata;
            end else begin
               w_sec_ready = 1'b1;
               if (bus.sec_valid) begin
                  w_mem_en = 1'b1;
                  w_mem_we = bus.sec_we;
               end else begin
                  w_mem_en = 1'b0;
                  w_mem_we = 4'h0;
               end
            end
         end
         ST_FORCED: begin
            // CPU is held off; cpu_we never reaches the memory here
            w_sec_ready = 1'b1;
            w_cpu_stall = bus.cpu_req;
            if (bus.sec_valid) begin
               w_mem_en = 1'b1;
               w_mem_we = bus.sec_we;
            end else begin
               w_mem_en = 1'b0;
               w_mem_we = 4'h0;
            end
         end
         default: begin
            w_mem_en    = 1'b0;
            w_mem_we    = 4'h0;
            w_sec_ready = 1'b0;
            w_cpu_stall = 1'b0;
         end
      endcase
   end

   assign w_handshake = bus.sec_valid & w_sec_ready;

   // Arbitration FSM: state, starve counter and pending secondary read
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state      <= ST_NORMAL;
         r_starve_cnt <= 4'd0;
         r_rd_pend    <= 1'b0;
      end else begin
         // one return per accepted read, always the cycle after acceptance
         r_rd_pend <= w_handshake & (bus.sec_we == 4'h0);
         case (r_state)
            ST_NORMAL: begin
               if (w_handshake || !bus.sec_valid) begin
                  r_starve_cnt <= 4'd0;
               end else if (r_starve_cnt == LIMIT_M1) begin
                  // counter would reach the limit: grant instead of counting
                  r_state      <= ST_FORCED;
                  r_starve_cnt <= 4'd0;
               end else begin
                  r_starve_cnt <= r_starve_cnt + 4'd1;
               end
            end
            ST_FORCED: begin
               r_state      <= ST_NORMAL;
               r_starve_cnt <= 4'd0;
            end
            default: begin
               r_state      <= ST_NORMAL;
               r_starve_cnt <= 4'd0;
            end
         endcase
      end
   end

   assign bus.mem_en     = w_mem_en;
   assign bus.mem_we     = w_mem_we;
   assign bus.mem_addr   = w_mem_addr;
   assign bus.mem_wdata  = w_mem_wdata;
   assign bus.sec_ready  = w_sec_ready;
   assign bus.cpu_stall  = w_cpu_stall;
   assign bus.sec_rvalid = r_rd_pend;
   assign bus.sec_rdata  = bus.mem_rdata;
   assign bus.cpu_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter (ADDR_W=10, STARVE_LIMIT=8) with a
// behavioural 1-cycle-latency byte-enabled BRAM. A vector table covers the
// single-cycle ownership mapping; hand-written sequences cover starvation,
// back-to-back reads and reset in the middle of activity.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   logic sys_clk;
   logic sys_rst_n;
   int   n_checks;
   int   n_pass;

   dmem_arbiter_if #(.ADDR_W(10)) bus ();

   dmem_arbiter #(.ADDR_W(10), .STARVE_LIMIT(8)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // BRAM model: read-first, byte enables, cleared while reset is low
   logic [31:0] mem [0:1023];
   logic [31:0] r_mem_rdata;
   assign bus.mem_rdata = r_mem_rdata;

   always @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      end else if (bus.mem_en) begin
         r_mem_rdata <= mem[bus.mem_addr];
         for (int b = 0; b < 4; b++)
            if (bus.mem_we[b]) mem[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input logic cr, input logic [3:0] cw, input logic [31:0] ca,
                        input logic [31:0] cd, input logic sv, input logic [3:0] sw,
                        input logic [31:0] sa, input logic [31:0] sd);
      bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
      bus.sec_valid = sv; bus.sec_we = sw; bus.sec_addr = sa; bus.sec_wdata = sd;
   endtask

   typedef struct {
      logic        cpu_req;  logic [3:0] cpu_we; logic [31:0] cpu_addr; logic [31:0] cpu_wdata;
      logic        sec_valid; logic [3:0] sec_we; logic [31:0] sec_addr; logic [31:0] sec_wdata;
      logic        e_en;     logic [3:0] e_we;   logic [9:0]  e_addr;   logic [31:0] e_wdata;
      logic        e_ready;  logic       e_stall; logic       e_rvalid;
      logic        chk_rd;   logic [31:0] e_rdata;
   } vec_t;

   vec_t vecs [0:14];

   initial begin
      n_checks = 0;
      n_pass   = 0;
      // cpu write, cpu read, idle (cpu_rdata), secondary read and its return
      vecs[0]  = '{1'b1,4'hF,32'h10,32'hDEADBEEF, 1'b0,4'h0,32'h0,32'h0,
                   1'b1,4'hF,10'h004,32'hDEADBEEF, 1'b0,1'b0,1'b0, 1'b0,32'h0};
      vecs[1]  = '{1'b1,4'h0,32'h10,32'h0, 1'b0,4'h0,32'h0,32'h0,
                   1'b1,4'h0,10'h004,32'h0, 1'b0,1'b0,1'b0, 1'b0,32'h0};
      vecs[2]  = '{1'b0,4'h0,32'h0,32'h0, 1'b0,4'h0,32'h0,32'h0,
                   1'b0,4'h0,10'h000,32'h0, 1'b1,1'b0,1'b0, 1'b1,32'hDEADBEEF};
      vecs[3]  = '{1'b0,4'h0,32'h0,32'h0, 1'b1,4'h0,32'h10,32'h0,
                   1'b1,4'h0,10'h004,32'h0, 1'b1,1'b0,1'b0, 1'b0,32'h0};
      vecs[4]  = '{1'b0,4'h0,32'h0,32'h0, 1'b0,4'h0,32'h0,32'h0,
                   1'b0,4'h0,10'h000,32'h0, 1'b1,1'b0,1'b1, 1'b0,32'hDEADBEEF};
      vecs[5]  = '{1'b0,4'h0,32'h0,32'h0, 1'b0,4'h0,32'h0,32'h0,
                   1'b0,4'h0,10'h000,32'h0, 1'b1,1'b0,1'b0, 1'b0,32'h0};
      // secondary partial write with high address bits wrapping away
      vecs[6]  = '{1'b0,4'h0,32'h0,32'h0, 1'b1,4'b0011,32'h3FFC,32'h12345678,
                   1'b1,4'b0011,10'h3FF,32'h12345678, 1'b1,1'b0,1'b0, 1'b0,32'h0};
      vecs[7]  = '{1'b0,4'h0,32'h0,32'h0, 1'b0,4'h0,32'h0,32'h0,
                   1'b0,4'h0,10'h000,32'h0, 1'b1,1'b0,1'b0, 1'b0,32'h0};
      vecs[8]  = '{1'b0,4'h0,32'h0,32'h0, 1'b1,4'h0,32'h3FFC,32'h0,
                   1'b1,4'h0,10'h3FF,32'h0, 1'b1,1'b0,1'b0, 1'b0,32'h0};
      vecs[9]  = '{1'b0,4'h0,32'h0,32'h0, 1'b0,4'h0,32'h0,32'h0,
                   1'b0,4'h0,10'h000,32'h0, 1'b1,1'b0,1'b1, 1'b0,32'h00005678};
      // CPU wins a contended cycle, then the secondary gets through
      vecs[10] = '{1'b1,4'b1000,32'h20,32'hAABBCCDD, 1'b1,4'h0,32'h10,32'h0,
                   1'b1,4'b1000,10'h008,32'hAABBCCDD, 1'b0,1'b0,1'b0, 1'b0,32'h0};
      vecs[11] = '{1'b0,4'h0,32'h0,32'h0, 1'b1,4'h0,32'h10,32'h0,
                   1'b1,4'h0,10'h004,32'h0, 1'b1,1'b0,1'b0, 1'b0,32'h0};
      vecs[12] = '{1'b0,4'h0,32'h0,32'h0, 1'b0,4'h0,32'h0,32'h0,
                   1'b0,4'h0,10'h000,32'h0, 1'b1,1'b0,1'b1, 1'b0,32'hDEADBEEF};
      // CPU read with junk in bits [1:0] and above bit 11
      vecs[13] = '{1'b1,4'h0,32'hFFFFF023,32'h0, 1'b0,4'h0,32'h0,32'h0,
                   1'b1,4'h0,10'h008,32'h0, 1'b0,1'b0,1'b0, 1'b0,32'h0};
      vecs[14] = '{1'b0,4'h0,32'h0,32'h0, 1'b0,4'h0,32'h0,32'h0,
                   1'b0,4'h0,10'h000,32'h0, 1'b1,1'b0,1'b0, 1'b1,32'hAA000000};

      // ---------------- reset state ----------------
      sys_rst_n = 1'b0;
      drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge sys_clk); @(negedge sys_clk);
      chk("rst_rvalid", 32'(bus.sec_rvalid), 32'd0);
      chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_ready",  32'(bus.sec_ready), 32'd1);
      chk("rst_stall",  32'(bus.cpu_stall), 32'd0);
      sys_rst_n = 1'b1;
      @(posedge sys_clk); #1;

      // ---------------- vector table ----------------
      for (int v = 0; v < 15; v++) begin
         drive(vecs[v].cpu_req, vecs[v].cpu_we, vecs[v].cpu_addr, vecs[v].cpu_wdata,
               vecs[v].sec_valid, vecs[v].sec_we, vecs[v].sec_addr, vecs[v].sec_wdata);
         @(negedge sys_clk);
         chk($sformatf("v%0d_mem_en", v), 32'(bus.mem_en), 32'(vecs[v].e_en));
         chk($sformatf("v%0d_mem_we", v), 32'(bus.mem_we), 32'(vecs[v].e_we));
         if (vecs[v].e_en) begin
            chk($sformatf("v%0d_mem_addr", v), 32'(bus.mem_addr), 32'(vecs[v].e_addr));
            chk($sformatf("v%0d_mem_wdata", v), bus.mem_wdata, vecs[v].e_wdata);
         end
         chk($sformatf("v%0d_ready", v), 32'(bus.sec_ready), 32'(vecs[v].e_ready));
         chk($sformatf("v%0d_stall", v), 32'(bus.cpu_stall), 32'(vecs[v].e_stall));
         chk($sformatf("v%0d_rvalid", v), 32'(bus.sec_rvalid), 32'(vecs[v].e_rvalid));
         if (vecs[v].e_rvalid) chk($sformatf("v%0d_sec_rdata", v), bus.sec_rdata, vecs[v].e_rdata);
         if (vecs[v].chk_rd)   chk($sformatf("v%0d_cpu_rdata", v), bus.cpu_rdata, vecs[v].e_rdata);
         @(posedge sys_clk); #1;
      end

      // ---------------- starvation: 8 denials, 1 forced, repeating ----------------
      drive(1'b1, 4'hF, 32'h40, 32'h55555555, 1'b1, 4'h0, 32'h10, 32'h0);
      for (int k = 1; k <= 18; k++) begin
         logic exp_f;
         exp_f = ((k % 9) == 0);
         @(negedge sys_clk);
         chk($sformatf("starve%0d_ready", k), 32'(bus.sec_ready), 32'(exp_f));
         chk($sformatf("starve%0d_stall", k), 32'(bus.cpu_stall), 32'(exp_f));
         chk($sformatf("starve%0d_mem_we", k), 32'(bus.mem_we), exp_f ? 32'h0 : 32'hF);
         chk($sformatf("starve%0d_mem_addr", k), 32'(bus.mem_addr), exp_f ? 32'h4 : 32'h10);
         chk($sformatf("starve%0d_rvalid", k), 32'(bus.sec_rvalid), 32'(k == 10));
         if (k == 10) chk("starve10_sec_rdata", bus.sec_rdata, 32'hDEADBEEF);
      end
      @(posedge sys_clk); #1;
      drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge sys_clk);
      chk("starve_tail_rvalid", 32'(bus.sec_rvalid), 32'd1);
      chk("starve_tail_rdata", bus.sec_rdata, 32'hDEADBEEF);
      @(posedge sys_clk); #1;

      // ---------------- three back-to-back secondary reads ----------------
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'hF, 32'h100 + 32'(4*i), 32'h11111111 * 32'(i+1), 1'b0, 4'h0, 32'h0, 32'h0);
         @(posedge sys_clk); #1;
      end
      for (int i = 0; i < 5; i++) begin
         if (i < 3) drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h100 + 32'(4*i), 32'h0);
         else       drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
         @(negedge sys_clk);
         if (i < 3) chk($sformatf("b2b%0d_ready", i), 32'(bus.sec_ready), 32'd1);
         chk($sformatf("b2b%0d_rvalid", i), 32'(bus.sec_rvalid), 32'(i >= 1 && i <= 3));
         if (i >= 1 && i <= 3)
            chk($sformatf("b2b%0d_rdata", i), bus.sec_rdata, 32'h11111111 * 32'(i));
         @(posedge sys_clk); #1;
      end

      // ---------------- reset mid-count restarts the starve counter ----------------
      drive(1'b1, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h10, 32'h0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge sys_clk);
         chk($sformatf("pre_rst%0d_ready", k), 32'(bus.sec_ready), 32'd0);
      end
      sys_rst_n = 1'b0;
      #1;
      chk("in_rst_ready", 32'(bus.sec_ready), 32'd0);
      chk("in_rst_mem_en", 32'(bus.mem_en), 32'd1);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         if (k > 1) @(negedge sys_clk);
         chk($sformatf("post_rst%0d_ready", k), 32'(bus.sec_ready), 32'(k == 9));
         chk($sformatf("post_rst%0d_stall", k), 32'(bus.cpu_stall), 32'(k == 9));
      end
      @(posedge sys_clk); #1;
      drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(posedge sys_clk); #1;

      // ---------------- reset discards a pending secondary read ----------------
      drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h10, 32'h0);
      @(negedge sys_clk);
      chk("pend_ready", 32'(bus.sec_ready), 32'd1);
      @(posedge sys_clk); #1;
      drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
      sys_rst_n = 1'b0;
      #1;
      chk("pend_rst_rvalid", 32'(bus.sec_rvalid), 32'd0);
      sys_rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge sys_clk);
         chk($sformatf("pend_after%0d_rvalid", k), 32'(bus.sec_rvalid), 32'd0);
         chk($sformatf("pend_after%0d_mem_en", k), 32'(bus.mem_en), 32'd0);
      end
      // NORMAL state: CPU request takes the memory immediately
      drive(1'b1, 4'h0, 32'h8, 32'h0, 1'b1, 4'h0, 32'h10, 32'h0);
      #1;
      chk("pend_normal_ready", 32'(bus.sec_ready), 32'd0);
      chk("pend_normal_stall", 32'(bus.cpu_stall), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
